period_meter: RTL and testbench
===============================

# period_meter

Measures the period (and, optionally, the high time) of a slow external square wave in system-clock cycles. It is the inverse of the team's clock divider: the divider derives a 1 kHz strobe from the 50 MHz clock, and this block takes such a strobe, or any external pulse train, and reports its period. It sits between an asynchronous input pin and the display/readout logic, so a 1 kHz input at 50 MHz reads back as 50000.

## Interface

Parameters:

- WIDTH, 20: width of the period and high-time results and of the internal counter.
- TIMEOUT, 1000000: cycles without a rising edge before the measurement is abandoned. Must satisfy TIMEOUT ≤ 2**WIDTH−1.

Ports:

- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low; clears all state.
- sig_in  in  1  asynchronous input signal to be measured.
- period  out  WIDTH  last measured period in clock cycles.
- high_time  out  WIDTH  last measured high time in cycles. Driven only with PERIOD_METER_DUTY_EN; tied to 0 otherwise.
- valid  out  1  one-cycle pulse when period/high_time update.
- timeout  out  1  sticky flag: no rising edge seen within TIMEOUT cycles.

## Operation

- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a third flop holds the previous value.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- State machine:
  - IDLE (reset state): counter held at 0. On rise → MEASURE with cnt ← 0. No valid is produced, because the first edge only arms the block.
  - MEASURE: cnt increments every cycle.
    - On rise: period ← cnt+1, valid pulses, cnt ← 0, stay in MEASURE.
    - On cnt == TIMEOUT−1 with no rise: → IDLE, timeout ← 1, period ← 0, no valid.
- Duty (macro enabled): on fall in MEASURE, hold_high ← cnt+1. On the next rise, high_time ← hold_high together with period.
- timeout clears on the next valid pulse. A rise that coincides with cnt == TIMEOUT−1 counts as a valid measurement, so no timeout is raised.
- Arithmetic: cnt+1 is computed at WIDTH bits. It cannot wrap because TIMEOUT ≤ 2**WIDTH−1.
- Input levels shorter than 2 clock cycles may be missed. The reported period is then the interval between detected rises; no error is flagged.
- Reset asserted mid-measurement: immediate return to IDLE. All outputs and registers go to 0, including timeout. The next rise re-arms the block.

## Timing

- Reset values: period=0, high_time=0, valid=0, timeout=0, state=IDLE, synchronizer flops=0.
- Edge-detect latency is 3 cycles from a sig_in transition to rise/fall. This latency is identical for every edge, so the measured interval is exact.
- valid is high for the single cycle after the rise-detect cycle. period/high_time change only on that same edge and hold until the next valid or timeout.
- Timeout is reported TIMEOUT cycles after the last detected rise. timeout goes high on the same edge that period clears.
- Consecutive valid pulses are at least 4 cycles apart (minimum detectable period).

## Configuration

- PERIOD_METER_DUTY_EN defined:
  - fall detection and the hold_high register are built.
  - high_time reports the high time.
- Not defined:
  - the fall logic and hold_high are omitted.
  - high_time is constant 0.
  - period, valid and timeout behaviour is unchanged.

## Structure

- Shared package holds:
  - the state enum {IDLE, MEASURE};
  - the default constants CLK_HZ=50000000, DEF_WIDTH=20, DEF_TIMEOUT=1000000.
- One sub-module: edge_sync (2-flop synchronizer plus previous-value flop, outputs rise/fall). It is reusable for other pin inputs.

## Test plan

- Reset, then a 1 kHz square wave (50000-cycle period, 25000 high): first rise gives no valid. Each later rise gives period=50000, high_time=25000 (duty enabled), one-cycle valid.
- Period 4 cycles (2 high, 2 low): period=4, high_time=2 on every rise; valid pulses every 4 cycles.
- Input stuck low after one rise, TIMEOUT=1000: timeout=1 and period=0 exactly 1000 cycles after the rise-detect cycle. The next two rises produce period=interval and clear timeout.
- Rise landing exactly on cnt == TIMEOUT−1: valid with period=TIMEOUT, timeout stays 0.
- reset pulsed low mid-period: all outputs 0 immediately, state IDLE. The first subsequent rise gives no valid; the second gives the correct period.
- Build without PERIOD_METER_DUTY_EN, 30% duty, 10000-cycle period: period=10000, high_time=0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter and its edge synchronizer.
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int CLK_HZ      = 50000000;
    localparam int DEF_WIDTH   = 20;
    localparam int DEF_TIMEOUT = 1000000;

endpackage

// File: rtl/period_meter_if.sv
// Pin-side and readout-side signals of the period meter, grouped for hookup.
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             timeout;

    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output timeout
    );
endinterface

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchronizer plus a previous-value flop; reusable for any slow pin input.
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period (and high time when PERIOD_METER_DUTY_EN is defined) of a slow
// asynchronous square wave in clock cycles, with a sticky no-edge timeout flag.
//
//   state   | meaning
//   IDLE    | counter parked at 0, waiting for a rise to arm
//   MEASURE | counting cycles since the last detected rise
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clock,
    input  logic         reset,
    period_meter_if.slave pm
);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             timeout_q;
    logic [WIDTH-1:0] cnt_plus1;
    logic             rise;

`ifdef PERIOD_METER_DUTY_EN
    logic             fall;
    logic [WIDTH-1:0] hold_high_q;
    logic [WIDTH-1:0] high_time_q;
`else
    logic             fall_unused;
`endif

    edge_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .sig_i  (pm.sig_in),
        .rise_o (rise),
`ifdef PERIOD_METER_DUTY_EN
        .fall_o (fall)
`else
        .fall_o (fall_unused)
`endif
    );

    // Cannot wrap: TIMEOUT never exceeds the counter's full scale.
    assign cnt_plus1 = cnt_q + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
            hold_high_q <= '0;
            high_time_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the last counted cycle wins over the timeout.
                    if (rise) begin
                        period_q  <= cnt_plus1;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        cnt_q     <= '0;
`ifdef PERIOD_METER_DUTY_EN
                        high_time_q <= hold_high_q;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_plus1;
                    end
`ifdef PERIOD_METER_DUTY_EN
                    if (fall) begin
                        hold_high_q <= cnt_plus1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pm.period  = period_q;
    assign pm.valid   = valid_q;
    assign pm.timeout = timeout_q;
`ifdef PERIOD_METER_DUTY_EN
    assign pm.high_time = high_time_q;
`else
    assign pm.high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a short-timeout instance for edge cases and a default
// instance for the 1 kHz / 10000-cycle waveforms, both checked through a scoreboard.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int W    = 20;
    localparam int TO_A = 1000;
`ifdef PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        int h;
        int l;
        int per;
        int hi;
    } vec_t;

    typedef struct {
        int per;
        int hi;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;

    always #10 clock = ~clock;

    period_meter_if #(.WIDTH(W)) pa ();
    period_meter_if #(.WIDTH(W)) pb ();

    period_meter #(.WIDTH(W), .TIMEOUT(TO_A)) dut_a (
        .clock (clock),
        .reset (reset_a),
        .pm    (pa.slave)
    );

    period_meter #(.WIDTH(W), .TIMEOUT(DEF_TIMEOUT)) dut_b (
        .clock (clock),
        .reset (reset_b),
        .pm    (pb.slave)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic int exp_hi(int h);
        return DUTY ? h : 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_a(int h, int l);
        pa.sig_in = 1'b1;
        tick(h);
        pa.sig_in = 1'b0;
        tick(l);
    endtask

    task automatic drive_b(int h, int l);
        pb.sig_in = 1'b1;
        tick(h);
        pb.sig_in = 1'b0;
        tick(l);
    endtask

    logic prev_va = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (pa.valid === 1'b1) begin
            check("valid_a_width", 32'(prev_va), 32'd0);
            if (qa.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL valid_a_unexpected: got valid with period %0d, expected no valid", pa.period);
            end else begin
                e = qa.pop_front();
                check("period_a", 32'(pa.period), 32'(e.per));
                check("high_a", 32'(pa.high_time), 32'(e.hi));
                check("timeout_a_at_valid", 32'(pa.timeout), 32'd0);
            end
        end
        prev_va = pa.valid;
    end

    logic prev_vb = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (pb.valid === 1'b1) begin
            check("valid_b_width", 32'(prev_vb), 32'd0);
            if (qb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL valid_b_unexpected: got valid with period %0d, expected no valid", pb.period);
            end else begin
                e = qb.pop_front();
                check("period_b", 32'(pb.period), 32'(e.per));
                check("high_b", 32'(pb.high_time), 32'(e.hi));
                check("timeout_b_at_valid", 32'(pb.timeout), 32'd0);
            end
        end
        prev_vb = pb.valid;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t va[8];
        vec_t vb[2];
        int   n;
        bit   found;

        va[0] = '{2, 2, 4, 2};
        va[1] = '{2, 2, 4, 2};
        va[2] = '{2, 2, 4, 2};
        va[3] = '{3, 2, 5, 3};
        va[4] = '{2, 5, 7, 2};
        va[5] = '{10, 20, 30, 10};
        va[6] = '{100, 200, 300, 100};
        va[7] = '{500, 499, 999, 500};
        vb[0] = '{3000, 7000, 10000, 3000};
        vb[1] = '{25000, 25000, 50000, 25000};

        pa.sig_in = 1'b0;
        pb.sig_in = 1'b0;
        tick(3);
        check("reset_period_a", 32'(pa.period), 32'd0);
        check("reset_high_a", 32'(pa.high_time), 32'd0);
        check("reset_valid_a", 32'(pa.valid), 32'd0);
        check("reset_timeout_a", 32'(pa.timeout), 32'd0);
        check("reset_period_b", 32'(pb.period), 32'd0);
        check("reset_timeout_b", 32'(pb.timeout), 32'd0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick(3);

        fork
            begin
                // First rise of the table only arms; each segment is measured at the next rise.
                for (int i = 0; i < 8; i++) begin
                    qa.push_back('{va[i].per, exp_hi(va[i].hi)});
                    drive_a(va[i].h, va[i].l);
                end

                pa.sig_in = 1'b1;
                n = 0;
                found = 1'b0;
                while (n < 1100 && !found) begin
                    tick(1);
                    n++;
                    if (n == 2) pa.sig_in = 1'b0;
                    if (pa.timeout === 1'b1) found = 1'b1;
                end
                check("timeout_a_latency", 32'(n), 32'(3 + TO_A));
                check("timeout_a_period", 32'(pa.period), 32'd0);

                qa.push_back('{20, exp_hi(5)});
                drive_a(5, 15);
                check("timeout_a_sticky", 32'(pa.timeout), 32'd1);
                qa.push_back('{TO_A, exp_hi(4)});
                drive_a(4, TO_A - 4);
                check("timeout_a_cleared", 32'(pa.timeout), 32'd0);

                pa.sig_in = 1'b1;
                tick(2);
                pa.sig_in = 1'b0;
                tick(40);
                check("boundary_a_period", 32'(pa.period), 32'(TO_A));
                check("boundary_a_timeout", 32'(pa.timeout), 32'd0);

                reset_a = 1'b0;
                #1;
                check("midreset_a_period", 32'(pa.period), 32'd0);
                check("midreset_a_high", 32'(pa.high_time), 32'd0);
                check("midreset_a_valid", 32'(pa.valid), 32'd0);
                check("midreset_a_timeout", 32'(pa.timeout), 32'd0);
                tick(2);
                reset_a = 1'b1;
                tick(2);

                qa.push_back('{20, exp_hi(6)});
                drive_a(6, 14);
                qa.push_back('{7, exp_hi(3)});
                drive_a(3, 4);
                pa.sig_in = 1'b1;
                tick(2);
                pa.sig_in = 1'b0;

                n = 0;
                found = 1'b0;
                while (n < 1100 && !found) begin
                    tick(1);
                    n++;
                    if (pa.timeout === 1'b1) found = 1'b1;
                end
                check("timeout2_a_seen", 32'(found), 32'd1);
                reset_a = 1'b0;
                #1;
                check("reset_clears_timeout_a", 32'(pa.timeout), 32'd0);
                tick(2);
                reset_a = 1'b1;
                tick(2);
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    qb.push_back('{vb[i].per, exp_hi(vb[i].hi)});
                    drive_b(vb[i].h, vb[i].l);
                end
                pb.sig_in = 1'b1;
                tick(2);
                pb.sig_in = 1'b0;
                tick(8);
                check("period_b_hold", 32'(pb.period), 32'd50000);
            end
        join

        check("queue_a_drained", 32'(qa.size()), 32'd0);
        check("queue_b_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
